mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Bus initiator that drives the single-port 256x16 data memory (clk, we, address, write_data in; registered read_data out, 1-cycle read latency).
- Performs block copy (memory to memory) and block fill (constant to memory) on a start pulse from the CPU control path.
- Sits between the control unit and the memory port.
- Turns one command into a sequence of read/write bus cycles, then reports completion.

Parameters:
- ADDR_W, 8, memory address width; wraps modulo 2^ADDR_W.
- DATA_W, 16, memory word width.
- LEN_W, ADDR_W+1, length field width; allows a full 256-word transfer.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  ADDR_W  copy source base address.
- dst_addr  in  ADDR_W  destination base address.
- length  in  LEN_W  word count, 0..256.
- fill_data  in  DATA_W  fill constant.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- words_done  out  LEN_W  destination words written so far in current or last command.
- mem_we  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_rdata  in  DATA_W  from memory read_data; valid the cycle after address presented with we=0.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE; busy=0, done=0, words_done=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Applies immediately on rst_n low, including mid-command.
  - mem_we drops at once; the word in flight is not written.
  - No resume after reset release.
- Outputs are decoded from registered state, counters and latched operands only; there is no combinational path from command inputs to the memory port.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - busy=0, mem_we=0, mem_addr holds its last value, mem_wdata holds its last value.
  - On a clk edge with start=1: latch mode, src_addr, dst_addr, length and fill_data; clear idx and words_done.
  - Next state:
    - length=0 -> FIN.
    - mode=0 -> RD.
    - mode=1 -> WR.
- RD (copy only):
  - mem_we=0, mem_addr=src+idx (mod 2^ADDR_W), busy=1.
  - Next state: WR.
- WR:
  - mem_we=1, mem_addr=dst+idx (mod 2^ADDR_W), busy=1.
  - mem_wdata: copy -> mem_rdata (data read in the preceding RD cycle, passed straight through); fill -> latched fill_data.
  - At the edge ending WR: idx++, words_done++.
  - If idx+1==length -> FIN; else copy -> RD, fill -> WR.
- FIN: done=1 for exactly one cycle, busy=0, mem_we=0; next state IDLE.
- Latency from the start edge, for N = length:
  - Copy: 2N cycles of bus activity; done in cycle 2N+1.
  - Fill: N cycles; done in cycle N+1.
  - length=0: done in cycle 1, zero bus cycles.
- start while busy or in FIN: ignored, not queued; operand inputs are don't-care outside the start edge.
- Address wrap: src/dst+idx wraps past 255 to 0; a 256-word transfer touches every address exactly once.
- Overlap: copy is strictly ascending, word-serial (each word is read before it is written).
  - dst > src and overlapping -> source data is replicated (defined behaviour, not an error).
  - dst == src -> memory unchanged.
- words_done holds its final value after FIN until the next accepted start.

Test Plan:
- Fill: start, mode=1, dst=0x10, length=4, fill_data=0xBEEF -> four consecutive mem_we=1 cycles at addresses 0x10..0x13, done in cycle 5, words_done=4, memory readback 0xBEEF at 0x10..0x13.
- Copy: preload 0x20..0x22 = 0x1111, 0x2222, 0x3333; start mode=0 src=0x20 dst=0x80 length=3 -> alternating RD/WR bus cycles, done in cycle 7, 0x80..0x82 match the source.
- Wrap and length edges: fill dst=0xFE length=4 -> writes 0xFE, 0xFF, 0x00, 0x01. length=0 -> done in cycle 1, mem_we never asserted. length=256 fill -> all 256 words written, words_done=256.
- Start while busy: second start (different operands) during the copy above -> ignored, original transfer completes unchanged, a single done pulse.
- Async reset mid-copy: drop rst_n during a WR cycle -> mem_we=0, busy=0 and all outputs 0 before the next edge. After release: IDLE, no further writes, and a new start executes normally.
- Overlap: preload 0x40 = 0xA5A5, 0x41 = 0x0001; copy src=0x40 dst=0x41 length=2 -> 0x41 = 0xA5A5, 0x42 = 0xA5A5.

Source files
------------

// File: rtl/mem_block_mover.sv
// Bus initiator for the 256x16 data memory: turns one copy or fill command
// into a word-serial sequence of read/write bus cycles and pulses done at the end.
module mem_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_srcAddr;
  logic [ADDR_W-1:0]   r_dstAddr;
  logic [LEN_W-1:0]    r_length;
  logic [DATA_W-1:0]   r_fillData;
  logic [LEN_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_lastAddr;
  logic [DATA_W-1:0]   r_lastWdata;
  logic [LEN_W-1:0]    w_idxNext;
  logic [ADDR_W-1:0]   w_offset;
  logic                w_lastWord;

  // The word index doubles as the words_done count: one write per index step.
  assign w_idxNext  = r_idx + LEN_W'(1);
  assign w_offset   = r_idx[ADDR_W-1:0];
  assign w_lastWord = (w_idxNext == r_length);
  assign words_done = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length == '0) w_nextState = FIN;
          else if (mode)    w_nextState = WR;
          else              w_nextState = RD;
        end
      end
      RD:  w_nextState = WR;
      WR: begin
        if (w_lastWord)  w_nextState = FIN;
        else if (r_mode) w_nextState = WR;
        else             w_nextState = RD;
      end
      FIN: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are latched only on an accepted start; the bus port then holds
  // its last driven address/data while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_srcAddr   <= '0;
      r_dstAddr   <= '0;
      r_length    <= '0;
      r_fillData  <= '0;
      r_idx       <= '0;
      r_lastAddr  <= '0;
      r_lastWdata <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_mode     <= mode;
        r_srcAddr  <= src_addr;
        r_dstAddr  <= dst_addr;
        r_length   <= length;
        r_fillData <= fill_data;
        r_idx      <= '0;
      end
      if (r_state == WR) begin
        r_idx       <= w_idxNext;
        r_lastWdata <= mem_wdata;
      end
      if (r_state == RD || r_state == WR) r_lastAddr <= mem_addr;
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_lastAddr;
    mem_wdata = r_lastWdata;
    case (r_state)
      RD: begin
        busy     = 1'b1;
        mem_addr = r_srcAddr + w_offset;
      end
      WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_dstAddr + w_offset;
        mem_wdata = r_mode ? r_fillData : mem_rdata;
      end
      FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench for mem_block_mover: a bench-side 256x16 memory plus a
// sequential word-by-word reference of copy/fill, directed and random commands.
module tb_mem_block_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  length;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic [8:0]  words_done;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] tbMem  [256];
  logic [15:0] refMem [256];
  logic        pokeEn;
  logic [7:0]  pokeAddr;
  logic [15:0] pokeData;
  logic [23:0] writeLog [$];
  int          doneCount;
  int          checks = 0;
  int          errors = 0;

  mem_block_mover #(.ADDR_W(8), .DATA_W(16), .LEN_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .busy(busy), .done(done), .words_done(words_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read; pokes preload it while the mover is idle.
  always @(posedge clk) begin
    if (pokeEn)      tbMem[pokeAddr] <= pokeData;
    else if (mem_we) tbMem[mem_addr] <= mem_wdata;
    mem_rdata <= tbMem[mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_we === 1'b1) writeLog.push_back({mem_addr, mem_wdata});
      if (done === 1'b1) doneCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pokeWord(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pokeEn   = 1'b1;
    pokeAddr = a;
    pokeData = d;
    refMem[a] = d;
  endtask

  task automatic pokeDone();
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  function automatic int memDiffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (tbMem[i] !== refMem[i]) n++;
    return n;
  endfunction

  task automatic randomOperands();
    mode      = 1'($urandom);
    src_addr  = 8'($urandom);
    dst_addr  = 8'($urandom);
    length    = 9'($urandom_range(1, 256));
    fill_data = 16'($urandom);
  endtask

  // Word-serial reference: each destination word takes the current source word.
  task automatic modelCommand(input logic m, input logic [7:0] s, input logic [7:0] d,
                              input int n, input logic [15:0] f, output logic [23:0] expLog [$]);
    logic [7:0]  a;
    logic [15:0] w;
    expLog.delete();
    for (int i = 0; i < n; i++) begin
      a = 8'((int'(d) + i) % 256);
      w = m ? f : refMem[(int'(s) + i) % 256];
      refMem[a] = w;
      expLog.push_back({a, w});
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [8:0] len, input logic [15:0] f,
                               input int interfere, input string tag);
    int          cyc;
    int          doneCyc;
    int          expCycles;
    int          mism;
    logic        busyFirst;
    logic [23:0] expLog [$];
    writeLog.delete();
    doneCount = 0;
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_data = f;
    @(negedge clk);
    cyc = 1;
    doneCyc = -1;
    busyFirst = busy;
    while (cyc <= 600) begin
      if (done === 1'b1 && doneCyc < 0) doneCyc = cyc;
      if (doneCyc >= 0 && cyc >= doneCyc + 2) break;
      if (cyc == interfere && (doneCyc < 0 || cyc == doneCyc)) begin
        randomOperands();
        start = 1'b1;
      end else begin
        start = 1'b0;
        randomOperands();
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    #1;
    expCycles = (len == 0) ? 1 : (m ? int'(len) + 1 : 2 * int'(len) + 1);
    modelCommand(m, s, d, int'(len), f, expLog);
    mism = 0;
    for (int i = 0; i < expLog.size(); i++)
      if (i >= writeLog.size() || writeLog[i] !== expLog[i]) mism++;
    checkOutput({tag, "/busyCycle1"}, 32'(busyFirst), 32'(len != 0));
    checkOutput({tag, "/doneCycle"}, doneCyc, expCycles);
    checkOutput({tag, "/donePulses"}, doneCount, 1);
    checkOutput({tag, "/writeCount"}, writeLog.size(), expLog.size());
    checkOutput({tag, "/writeMismatches"}, mism, 0);
    checkOutput({tag, "/wordsDone"}, 32'(words_done), 32'(len));
    checkOutput({tag, "/busyAfter"}, 32'(busy), 0);
    checkOutput({tag, "/memDiffs"}, memDiffs(), 0);
  endtask

  initial begin
    int          wr;
    int          seen;
    logic [8:0]  rlen;
    int          rint;
    rst_n = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_data = '0; pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset/busy", 32'(busy), 0);
    checkOutput("reset/done", 32'(done), 0);
    checkOutput("reset/memWe", 32'(mem_we), 0);
    checkOutput("reset/memAddr", 32'(mem_addr), 0);
    checkOutput("reset/memWdata", 32'(mem_wdata), 0);
    checkOutput("reset/wordsDone", 32'(words_done), 0);
    for (int i = 0; i < 256; i++) pokeWord(8'(i), 16'($urandom));
    pokeDone();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] directed commands");

    applyStimulus(1'b1, 8'h00, 8'h10, 9'd4, 16'hBEEF, 5, "fill4");
    checkOutput("fill4/readback", {16'h0, tbMem[8'h12]}, 32'hBEEF);

    pokeWord(8'h20, 16'h1111); pokeWord(8'h21, 16'h2222); pokeWord(8'h22, 16'h3333);
    pokeDone();
    applyStimulus(1'b0, 8'h20, 8'h80, 9'd3, 16'h0, 2, "copy3busyStart");
    checkOutput("copy3/readback", {16'h0, tbMem[8'h82]}, 32'h3333);

    applyStimulus(1'b1, 8'h00, 8'hFE, 9'd4, 16'h5A5A, 0, "fillWrap");
    checkOutput("fillWrap/addr01", {16'h0, tbMem[8'h01]}, 32'h5A5A);
    applyStimulus(1'b0, 8'h33, 8'h44, 9'd0, 16'h0, 1, "len0");
    applyStimulus(1'b1, 8'h00, 8'h37, 9'd256, 16'hC0DE, 0, "fill256");

    // Reset in the second write cycle of a copy.
    for (int i = 0; i < 8; i++) pokeWord(8'(8'h50 + i), 16'($urandom));
    pokeDone();
    writeLog.delete();
    doneCount = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 8'h50; dst_addr = 8'h60; length = 9'd8;
    @(negedge clk);
    start = 1'b0;
    wr = 0;
    for (int k = 0; k < 40; k++) begin
      if (mem_we === 1'b1) wr++;
      if (wr == 2) break;
      @(negedge clk);
    end
    #1;
    seen = writeLog.size();
    checkOutput("midReset/wrSeen", seen, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset/memWe", 32'(mem_we), 0);
    checkOutput("midReset/busy", 32'(busy), 0);
    checkOutput("midReset/done", 32'(done), 0);
    checkOutput("midReset/memAddr", 32'(mem_addr), 0);
    checkOutput("midReset/memWdata", 32'(mem_wdata), 0);
    checkOutput("midReset/wordsDone", 32'(words_done), 0);
    for (int i = 0; i < seen - 1; i++) refMem[8'h60 + i] = refMem[8'h50 + i];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("afterReset/noWrites", writeLog.size(), seen);
    checkOutput("afterReset/busy", 32'(busy), 0);
    checkOutput("afterReset/memDiffs", memDiffs(), 0);
    applyStimulus(1'b0, 8'h50, 8'h70, 9'd8, 16'h0, 0, "copyAfterReset");

    pokeWord(8'h40, 16'hA5A5); pokeWord(8'h41, 16'h0001);
    pokeDone();
    applyStimulus(1'b0, 8'h40, 8'h41, 9'd2, 16'h0, 0, "overlap");
    checkOutput("overlap/addr42", {16'h0, tbMem[8'h42]}, 32'hA5A5);
    applyStimulus(1'b0, 8'h90, 8'h90, 9'd5, 16'h0, 0, "sameAddr");

    $display("[TB] random commands");
    for (int n = 0; n < 12; n++) begin
      rlen = ($urandom_range(0, 7) == 0) ? 9'd256 : 9'($urandom_range(0, 40));
      rint = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), rlen, 16'($urandom),
                    rint, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
